// File: rtl/multicycle_ctrl.sv
// Main control FSM for the multicycle LEGv8 datapath: sequences fetch, decode, execute,
// memory and writeback, and counts retired instructions.
module multicycle_ctrl #(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [10:0]      op,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             memread,
  output logic             memwrite,
  output logic             iord,
  output logic             irwrite,
  output logic             pcen,
  output logic             pcsrc,
  output logic             reg2loc,
  output logic             regwrite,
  output logic             memtoreg,
  output logic             alusrca,
  output logic [1:0]       alusrcb,
  output logic [1:0]       aluop,
  output logic [3:0]       state,
  output logic [CNT_W-1:0] retired,
  output logic             halted
);

  typedef enum logic [3:0] {
    StFetch  = 4'd0,
    StDecode = 4'd1,
    StMemAdr = 4'd2,
    StMemRd  = 4'd3,
    StMemWb  = 4'd4,
    StMemWr  = 4'd5,
    StExec   = 4'd6,
    StAluWb  = 4'd7,
    StBranch = 4'd8,
    StHalt   = 4'd9
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] retired_q;
  logic             halted_q;
  logic             retire;
  logic             halt_set;
  logic             pcwrite;
  logic             pcwritecond;

  logic is_ldur, is_stur, is_rtype, is_cbz;

  assign is_ldur  = (op == 11'b11111000010);
  assign is_stur  = (op == 11'b11111000000);
  assign is_rtype = (op == 11'b10001011000) || (op == 11'b11001011000) ||
                    (op == 11'b10001010000) || (op == 11'b10101010000);
  assign is_cbz   = (op[10:3] == 8'b10110100);

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= StFetch;
      retired_q <= '0;
      halted_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      if (retire) begin
        retired_q <= retired_q + CNT_W'(1);
      end
      if (halt_set) begin
        halted_q <= 1'b1;
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    retire      = 1'b0;
    halt_set    = 1'b0;
    pcwrite     = 1'b0;
    pcwritecond = 1'b0;
    memread     = 1'b0;
    memwrite    = 1'b0;
    iord        = 1'b0;
    irwrite     = 1'b0;
    pcsrc       = 1'b0;
    reg2loc     = 1'b0;
    regwrite    = 1'b0;
    memtoreg    = 1'b0;
    alusrca     = 1'b0;
    alusrcb     = 2'b00;
    aluop       = 2'b00;

    case (state_q)
      StFetch: begin
        memread = 1'b1;
        alusrcb = 2'b01;
        irwrite = mem_ready;
        pcwrite = mem_ready;
        if (mem_ready) begin
          state_d = StDecode;
        end
      end
      StDecode: begin
        // Branch target is computed speculatively into ALUOut here.
        alusrcb = 2'b11;
        reg2loc = is_stur || is_cbz;
        if (is_ldur || is_stur) begin
          state_d = StMemAdr;
        end else if (is_rtype) begin
          state_d = StExec;
        end else if (is_cbz) begin
          state_d = StBranch;
        end else begin
          state_d  = StHalt;
          halt_set = 1'b1;
        end
      end
      StMemAdr: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
        state_d = is_ldur ? StMemRd : StMemWr;
      end
      StMemRd: begin
        memread = 1'b1;
        iord    = 1'b1;
        if (mem_ready) begin
          state_d = StMemWb;
        end
      end
      StMemWb: begin
        regwrite = 1'b1;
        memtoreg = 1'b1;
        state_d  = StFetch;
        retire   = 1'b1;
      end
      StMemWr: begin
        memwrite = 1'b1;
        iord     = 1'b1;
        reg2loc  = 1'b1;
        if (mem_ready) begin
          state_d = StFetch;
          retire  = 1'b1;
        end
      end
      StExec: begin
        alusrca = 1'b1;
        aluop   = 2'b10;
        state_d = StAluWb;
      end
      StAluWb: begin
        regwrite = 1'b1;
        state_d  = StFetch;
        retire   = 1'b1;
      end
      StBranch: begin
        reg2loc     = 1'b1;
        alusrca     = 1'b1;
        aluop       = 2'b01;
        pcsrc       = 1'b1;
        pcwritecond = 1'b1;
        state_d     = StFetch;
        retire      = 1'b1;
      end
      StHalt: begin
        state_d = StHalt;
      end
      default: begin
        state_d = StFetch;
      end
    endcase
  end

  assign pcen    = pcwrite | (pcwritecond & zero);
  assign state   = state_q;
  assign retired = retired_q;
  assign halted  = halted_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed self-checking bench for multicycle_ctrl, built with a 4-bit retired counter
// so wraparound is reachable.
module tb_multicycle_ctrl;

  localparam int unsigned CntW = 4;

  localparam logic [10:0] OpAdd  = 11'b10001011000;
  localparam logic [10:0] OpLdur = 11'b11111000010;
  localparam logic [10:0] OpStur = 11'b11111000000;
  localparam logic [10:0] OpCbz  = 11'b10110100101;
  localparam logic [10:0] OpBad  = 11'b00000000000;

  logic            clk;
  logic            reset;
  logic [10:0]     op;
  logic            zero;
  logic            mem_ready;
  logic            memread, memwrite, iord, irwrite, pcen, pcsrc, reg2loc;
  logic            regwrite, memtoreg, alusrca, halted;
  logic [1:0]      alusrcb, aluop;
  logic [3:0]      state;
  logic [CntW-1:0] retired;

  int checks;
  int failures;

  multicycle_ctrl #(.CNT_W(CntW)) dut (
    .clk       (clk),
    .reset     (reset),
    .op        (op),
    .zero      (zero),
    .mem_ready (mem_ready),
    .memread   (memread),
    .memwrite  (memwrite),
    .iord      (iord),
    .irwrite   (irwrite),
    .pcen      (pcen),
    .pcsrc     (pcsrc),
    .reg2loc   (reg2loc),
    .regwrite  (regwrite),
    .memtoreg  (memtoreg),
    .alusrca   (alusrca),
    .alusrcb   (alusrcb),
    .aluop     (aluop),
    .state     (state),
    .retired   (retired),
    .halted    (halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Advance one clock; sample 1ns after the edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // ADD with mem_ready=1 from FETCH back to FETCH.
  task automatic run_add();
    op = OpAdd;
    repeat (4) cyc();
  endtask

  initial begin
    checks    = 0;
    failures  = 0;
    reset     = 1'b0;
    op        = OpBad;
    zero      = 1'b0;
    mem_ready = 1'b1;
    cyc();
    cyc();
    reset = 1'b1;
    #1;
    check_eq("rst_state", 32'(state), 32'd0);
    check_eq("rst_retired", 32'(retired), 32'd0);
    check_eq("rst_halted", 32'(halted), 32'd0);
    check_eq("fetch_out", {memread, iord, alusrca, alusrcb, aluop, irwrite, pcen, pcsrc},
             32'b1_0_0_01_00_1_1_0);

    // ADD: 0,1,6,7,0
    op = OpAdd;
    cyc();
    check_eq("add_decode", 32'(state), 32'd1);
    check_eq("add_dec_out", {alusrca, alusrcb, aluop, reg2loc, pcen}, 32'b0_11_00_0_0);
    cyc();
    check_eq("add_exec", {state, alusrca, alusrcb, aluop}, {4'd6, 1'b1, 2'b00, 2'b10});
    cyc();
    check_eq("add_aluwb", {state, regwrite, memtoreg}, {4'd7, 1'b1, 1'b0});
    check_eq("add_ret_pre", 32'(retired), 32'd0);
    cyc();
    check_eq("add_done", {state, retired}, {4'd0, 4'd1});

    // LDUR with 3 stall cycles in MEMRD
    op = OpLdur;
    cyc();
    check_eq("ld_decode", 32'(state), 32'd1);
    cyc();
    check_eq("ld_memadr", {state, alusrca, alusrcb, aluop}, {4'd2, 1'b1, 2'b10, 2'b00});
    cyc();
    mem_ready = 1'b0;
    #1;
    check_eq("ld_memrd", {state, memread, iord}, {4'd3, 1'b1, 1'b1});
    for (int i = 0; i < 3; i++) begin
      cyc();
      check_eq("ld_stall", {state, memread, iord}, {4'd3, 1'b1, 1'b1});
    end
    mem_ready = 1'b1;
    cyc();
    check_eq("ld_memwb", {state, regwrite, memtoreg}, {4'd4, 1'b1, 1'b1});
    cyc();
    check_eq("ld_done", {state, retired}, {4'd0, 4'd2});

    // STUR, with one fetch stall and one write stall
    op        = OpStur;
    mem_ready = 1'b0;
    #1;
    check_eq("fetch_stall_en", {memread, irwrite, pcen}, 32'b100);
    cyc();
    check_eq("fetch_stall_st", 32'(state), 32'd0);
    mem_ready = 1'b1;
    cyc();
    check_eq("st_decode", {state, reg2loc}, {4'd1, 1'b1});
    cyc();
    cyc();
    check_eq("st_memwr", {state, memwrite, iord, reg2loc, memread},
             {4'd5, 1'b1, 1'b1, 1'b1, 1'b0});
    mem_ready = 1'b0;
    cyc();
    check_eq("st_stall", {state, memwrite, retired}, {4'd5, 1'b1, 4'd2});
    mem_ready = 1'b1;
    cyc();
    check_eq("st_done", {state, retired}, {4'd0, 4'd3});

    // CBZ taken
    op   = OpCbz;
    zero = 1'b1;
    cyc();
    check_eq("cbz_decode", {state, reg2loc}, {4'd1, 1'b1});
    cyc();
    check_eq("cbz_taken", {state, pcen, pcsrc, aluop, alusrca, alusrcb},
             {4'd8, 1'b1, 1'b1, 2'b01, 1'b1, 2'b00});
    cyc();
    check_eq("cbz_t_done", {state, retired}, {4'd0, 4'd4});

    // CBZ not taken
    zero = 1'b0;
    cyc();
    cyc();
    check_eq("cbz_nt", {state, pcen, pcsrc}, {4'd8, 1'b0, 1'b1});
    cyc();
    check_eq("cbz_nt_done", {state, retired}, {4'd0, 4'd5});

    // Illegal opcode -> HALT
    op = OpBad;
    cyc();
    check_eq("bad_decode", {state, halted}, {4'd1, 1'b0});
    for (int i = 0; i < 10; i++) begin
      cyc();
      check_eq("halt_hold", {state, halted, retired}, {4'd9, 1'b1, 4'd5});
      check_eq("halt_en", {memread, memwrite, irwrite, pcen, regwrite}, 32'd0);
    end
    reset = 1'b0;
    cyc();
    check_eq("halt_rst", {state, halted, retired}, {4'd0, 1'b0, 4'd0});
    reset = 1'b1;

    // Counter wrap with 17 R-type instructions
    for (int i = 1; i <= 17; i++) begin
      run_add();
      if (i == 15) check_eq("wrap_15", 32'(retired), 32'd15);
      if (i == 16) check_eq("wrap_0", 32'(retired), 32'd0);
    end
    check_eq("wrap_1", {state, retired}, {4'd0, 4'd1});

    // Reset during EXEC aborts the instruction
    op = OpAdd;
    cyc();
    cyc();
    check_eq("abort_exec", 32'(state), 32'd6);
    reset = 1'b0;
    cyc();
    check_eq("abort_rst", {state, retired}, {4'd0, 4'd0});
    reset = 1'b1;
    cyc();
    check_eq("abort_resume", {state, retired}, {4'd1, 4'd0});

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
